trace_buffer_drain: RTL and testbench

- Downstream consumer of the data packer: captures packed N-wide trace vectors into a circular buffer while tracing is active.
- After tracing stops, it replays the capture oldest-first as a serial, one-element-per-beat stream over a valid/ready port for the host readout path.
- Dump and clear are commanded through the shared configId/configData reconfiguration bus.

---
 rtl/trace_buffer_drain.sv | 194 +++++++++++++++++++
 tb/tb_trace_buffer_drain.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer_drain.sv
`default_nettype none
// ============================================================================
// Module   : trace_buffer_drain
// Purpose  : Captures packed N-wide trace vectors into a circular buffer
//            while tracing is high, then replays them oldest-first as a
//            serial one-element-per-beat valid/ready stream on DUMP.
//            DUMP / CLEAR arrive on the shared configId/configData bus.
// Revision : 1.0 - initial release
// ============================================================================
module trace_buffer_drain #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int TB_SIZE            = 8,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tracing,
  input  logic                        valid_in,
  input  logic [N*DATA_WIDTH-1:0]     vector_in,
  input  logic [7:0]                  configId,
  input  logic [7:0]                  configData,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_last,
  output logic [$clog2(TB_SIZE):0]    count,
  output logic                        overflow
);

  localparam int PTR_W  = $clog2(TB_SIZE);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ELEM_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(TB_SIZE);
  localparam logic [CNT_W-1:0]  ONE_COUNT  = CNT_W'(1);
  localparam logic [ELEM_W-1:0] LAST_ELEM  = ELEM_W'(N - 1);
  localparam logic [7:0]        MY_ID      = 8'(PERSONAL_CONFIG_ID);
  localparam logic [7:0]        CMD_DUMP   = 8'd1;
  localparam logic [7:0]        CMD_CLEAR  = 8'd2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Element 0 of a vector sits in the least significant DATA_WIDTH bits.
  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  vec_t                  mem_q [TB_SIZE];

  state_t                state_q,    state_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [ELEM_W-1:0]     elem_q,     elem_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q,  rd_last_d;
  logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;

  logic                  mem_we;
  logic                  load;

  // Next-state, pointer bookkeeping and output-register loading.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    elem_d     = elem_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tracing) begin
          if (valid_in) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == FULL_COUNT) begin
              // Buffer full: the oldest vector is dropped to make room.
              rd_ptr_d   = rd_ptr_q + 1'b1;
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end else if (configId == MY_ID) begin
          if (configData == CMD_DUMP) begin
            if (count_q != '0) begin
              state_d    = ST_DRAIN;
              rd_valid_d = 1'b1;
              elem_d     = '0;
              load       = 1'b1;
            end
          end else if (configData == CMD_CLEAR) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (tracing) begin
          // Abort: abandon the replay and drop whatever is left.
          state_d    = ST_IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          elem_d     = '0;
          count_d    = '0;
        end else if (rd_valid_q && rd_ready) begin
          if (rd_last_q) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            elem_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end else if (elem_q == LAST_ELEM) begin
            elem_d   = '0;
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            load     = 1'b1;
          end else begin
            elem_d = elem_q + 1'b1;
            load   = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The presented beat is fetched from the position it will occupy next,
    // so rd_data/rd_last only change on DUMP acceptance or a handshake.
    if (load) begin
      rd_data_d = mem_q[rd_ptr_d][elem_d];
      rd_last_d = (count_d == ONE_COUNT) && (elem_d == LAST_ELEM);
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      elem_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      elem_q     <= elem_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Trace storage; contents survive reset, but no write happens during it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wr_ptr_q] <= vector_in;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_buffer_drain
// Purpose  : Self-checking bench for trace_buffer_drain (N=8, TB_SIZE=4).
//            Expected streams come from a queue model of the trace buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_buffer_drain;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int TBS = 4;
  localparam int CW  = $clog2(TBS) + 1;
  localparam logic [7:0] MY_ID   = 8'd0;
  localparam logic [7:0] IDLE_ID = 8'hA5;
  localparam logic [7:0] OTHER_ID = 8'h01;

  typedef logic [CW-1:0]   cnt_t;
  typedef logic [N*DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tracing;
  logic          valid_in;
  vec_t          vector_in;
  logic [7:0]    configId;
  logic [7:0]    configData;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  cnt_t          count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of held vectors, sticky overflow, expected beats.
  vec_t          mq[$];
  bit            m_ovf;
  logic [DW-1:0] exp_q[$];

  // Beats gathered from the DUT during a dump.
  logic [DW-1:0] got_q[$];
  bit            last_q[$];
  int            hold_bad;
  int            cyc_used;
  bit            timed_out;

  trace_buffer_drain #(
    .N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS), .PERSONAL_CONFIG_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .vector_in(vector_in), .configId(configId), .configData(configData),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t dir_vec(input int k);
    vec_t v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 32'(16 * k + i);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom();
    return v;
  endfunction

  task automatic model_capture(input vec_t v);
    mq.push_back(v);
    if (mq.size() > TBS) begin
      mq.delete(0);
      m_ovf = 1'b1;
    end
  endtask

  // Full dump: every held vector, oldest first, element 0 first.
  task automatic model_dump();
    vec_t v;
    exp_q.delete();
    foreach (mq[k]) begin
      v = mq[k];
      for (int i = 0; i < N; i++) exp_q.push_back(v[i*DW +: DW]);
    end
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic capture(input vec_t v);
    tracing   = 1'b1;
    valid_in  = 1'b1;
    vector_in = v;
    step();
    valid_in  = 1'b0;
    model_capture(v);
  endtask

  task automatic command(input logic [7:0] id, input logic [7:0] cmd);
    tracing    = 1'b0;
    valid_in   = 1'b0;
    configId   = id;
    configData = cmd;
    step();
    configId   = IDLE_ID;
    configData = 8'h00;
  endtask

  // Drives rd_ready (0: always, 1: 1,0,0 pattern, else random) and records
  // accepted beats until the rd_last handshake or the cycle budget runs out.
  task automatic collect(input int mode, input int budget);
    logic [DW-1:0] pd;
    logic          pl;
    bit            stall;
    bit            done;
    got_q.delete();
    last_q.delete();
    hold_bad  = 0;
    cyc_used  = 0;
    timed_out = 1'b1;
    stall     = 1'b0;
    pd        = '0;
    pl        = 1'b0;
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (c % 3 == 0);
        default: rd_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (stall && (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl)) hold_bad++;
      done = 1'b0;
      if (rd_valid === 1'b1 && rd_ready) begin
        got_q.push_back(rd_data);
        last_q.push_back(rd_last === 1'b1);
        done = (rd_last === 1'b1);
      end
      stall = (rd_valid === 1'b1) && !rd_ready;
      pd    = rd_data;
      pl    = rd_last;
      step();
      cyc_used++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tracing = 1'b1; valid_in = 1'b1; vector_in = rand_vec();
    configId = IDLE_ID; configData = 8'h00; rd_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1; tracing = 1'b0; valid_in = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    total++; if (count !== cnt_t'(0)) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    total++; if (rd_last !== 1'b0) begin bad++; $display("FAIL rst_rd_last got=%b exp=0", rd_last); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    step();
    total++; if (count !== cnt_t'(0)) begin bad++; $display("FAIL rst_idle_count got=%0d exp=0", count); end
  endtask

  task automatic test_capture_dump();
    bit el;
    for (int k = 0; k < 3; k++) capture(dir_vec(k));
    total++; if (count !== cnt_t'(mq.size())) begin bad++; $display("FAIL cd_count got=%0d exp=%0d", count, mq.size()); end
    command(MY_ID, 8'd1);
    model_dump();
    collect(0, 100);
    total++; if (timed_out) begin bad++; $display("FAIL cd_timeout got=timeout exp=rd_last"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL cd_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    total++; if (cyc_used != exp_q.size()) begin bad++; $display("FAIL cd_cycles got=%0d exp=%0d", cyc_used, exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      el = (j == exp_q.size() - 1);
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL cd_data[%0d] got=%h exp=%h", j, got_q[j], exp_q[j]); end
      total++; if (last_q[j] !== el) begin bad++; $display("FAIL cd_last[%0d] got=%b exp=%b", j, last_q[j], el); end
    end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL cd_after_valid got=%b exp=0", rd_valid); end
    total++; if (count !== cnt_t'(0)) begin bad++; $display("FAIL cd_after_count got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    bit el;
    for (int k = 0; k < 6; k++) capture(dir_vec(k));
    total++; if (count !== cnt_t'(mq.size())) begin bad++; $display("FAIL ov_count got=%0d exp=%0d", count, mq.size()); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ov_flag got=%b exp=%b", overflow, m_ovf); end
    command(MY_ID, 8'd1);
    model_dump();
    collect(0, 100);
    total++; if (timed_out) begin bad++; $display("FAIL ov_timeout got=timeout exp=rd_last"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ov_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      el = (j == exp_q.size() - 1);
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL ov_data[%0d] got=%h exp=%h", j, got_q[j], exp_q[j]); end
      total++; if (last_q[j] !== el) begin bad++; $display("FAIL ov_last[%0d] got=%b exp=%b", j, last_q[j], el); end
    end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ov_after_flag got=%b exp=%b", overflow, m_ovf); end
  endtask

  task automatic test_backpressure();
    bit el;
    capture(rand_vec());
    command(MY_ID, 8'd1);
    model_dump();
    collect(1, 200);
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=timeout exp=rd_last"); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_bad); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      el = (j == exp_q.size() - 1);
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", j, got_q[j], exp_q[j]); end
      total++; if (last_q[j] !== el) begin bad++; $display("FAIL bp_last[%0d] got=%b exp=%b", j, last_q[j], el); end
    end
  endtask

  task automatic test_abort();
    bit   keep_ovf;
    vec_t x2;
    capture(rand_vec());
    capture(rand_vec());
    command(MY_ID, 8'd1);
    keep_ovf = m_ovf;
    model_dump();
    m_ovf = keep_ovf;
    rd_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[b]) begin
        bad++; $display("FAIL ab_beat[%0d] got=%b/%h exp=1/%h", b, rd_valid, rd_data, exp_q[b]);
      end
      step();
    end
    tracing = 1'b1; valid_in = 1'b1; vector_in = rand_vec();
    step();
    valid_in = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ab_valid got=%b exp=0", rd_valid); end
    total++; if (rd_last !== 1'b0) begin bad++; $display("FAIL ab_last got=%b exp=0", rd_last); end
    total++; if (count !== cnt_t'(0)) begin bad++; $display("FAIL ab_count got=%0d exp=0", count); end
    rd_ready = 1'b0;
    x2 = rand_vec();
    capture(x2);
    total++; if (count !== cnt_t'(mq.size())) begin bad++; $display("FAIL ab_recount got=%0d exp=%0d", count, mq.size()); end
    command(MY_ID, 8'd1);
    model_dump();
    collect(0, 50);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ab_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL ab_data[%0d] got=%h exp=%h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_clear();
    bit seen;
    for (int k = 0; k < 5; k++) capture(rand_vec());
    // Start a dump, take one beat, then abort: overflow stays, buffer empties.
    command(MY_ID, 8'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0; tracing = 1'b1; valid_in = 1'b0;
    step();
    mq.delete();
    for (int k = 0; k < 3; k++) capture(rand_vec());
    total++; if (count !== cnt_t'(mq.size())) begin bad++; $display("FAIL cl_pre_count got=%0d exp=%0d", count, mq.size()); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL cl_pre_ovf got=%b exp=%b", overflow, m_ovf); end
    command(OTHER_ID, 8'd2);
    command(MY_ID, 8'd3);
    total++; if (count !== cnt_t'(mq.size())) begin bad++; $display("FAIL cl_ignored got=%0d exp=%0d", count, mq.size()); end
    command(MY_ID, 8'd2);
    mq.delete(); m_ovf = 1'b0;
    total++; if (count !== cnt_t'(0)) begin bad++; $display("FAIL cl_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL cl_ovf got=%b exp=0", overflow); end
    command(MY_ID, 8'd1);
    rd_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rd_valid !== 1'b0) seen = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    total++; if (seen) begin bad++; $display("FAIL cl_empty_dump got=rd_valid exp=none"); end
    capture(rand_vec());
    capture(rand_vec());
    command(OTHER_ID, 8'd1);
    rd_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rd_valid !== 1'b0) seen = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    total++; if (seen) begin bad++; $display("FAIL cl_wrong_id got=rd_valid exp=none"); end
    total++; if (count !== cnt_t'(mq.size())) begin bad++; $display("FAIL cl_wrong_id_count got=%0d exp=%0d", count, mq.size()); end
    command(MY_ID, 8'd1);
    model_dump();
    collect(0, 50);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL cl_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL cl_data[%0d] got=%h exp=%h", j, got_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_random();
    int ncap;
    int ndone;
    bit el;
    for (int r = 0; r < 8; r++) begin
      ncap  = $urandom_range(1, 7);
      ndone = 0;
      while (ndone < ncap) begin
        case ($urandom_range(0, 3))
          0: begin
            tracing = 1'b1; valid_in = 1'b0;
            configId = 8'($urandom_range(0, 3)); configData = 8'($urandom_range(0, 3));
            step();
          end
          1: begin
            tracing = 1'b0; valid_in = 1'b1; vector_in = rand_vec();
            configId = IDLE_ID; configData = 8'($urandom_range(0, 3));
            step();
            valid_in = 1'b0;
          end
          default: begin
            configId = 8'($urandom_range(0, 3)); configData = 8'($urandom_range(0, 3));
            capture(rand_vec());
            ndone++;
          end
        endcase
      end
      total++; if (count !== cnt_t'(mq.size())) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, count, mq.size()); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd%0d_ovf got=%b exp=%b", r, overflow, m_ovf); end
      command(MY_ID, 8'd1);
      model_dump();
      collect(2, 400);
      total++; if (timed_out) begin bad++; $display("FAIL rnd%0d_timeout got=timeout exp=rd_last", r); end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL rnd%0d_hold got=%0d exp=0", r, hold_bad); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
        el = (j == exp_q.size() - 1);
        total++; if (got_q[j] !== exp_q[j]) begin bad++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", r, j, got_q[j], exp_q[j]); end
        total++; if (last_q[j] !== el) begin bad++; $display("FAIL rnd%0d_last[%0d] got=%b exp=%b", r, j, last_q[j], el); end
      end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_after_valid got=%b exp=0", r, rd_valid); end
      total++; if (count !== cnt_t'(0)) begin bad++; $display("FAIL rnd%0d_after_count got=%0d exp=0", r, count); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd%0d_after_ovf got=%b exp=%b", r, overflow, m_ovf); end
    end
  endtask

  initial begin
    rst_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; vector_in = '0;
    configId = IDLE_ID; configData = 8'h00; rd_ready = 1'b0;
    m_ovf = 1'b0;
    test_reset();
    test_capture_dump();
    test_overflow();
    test_backpressure();
    test_abort();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
